lsu_align_unit: RTL and testbench
=================================

Name: lsu_align_unit

Overview:
- Load/store unit between the datapath's memory request and the synchronous data RAM.
- Accepts byte, half and word requests at any byte address.
- Generates word-aligned RAM accesses with byte-lane masks, splitting word-crossing accesses into two RAM cycles.
- Returns sign- or zero-extended load data and a completion pulse, so the datapath stalls on the handshake instead of issuing RAM enables itself.

Parameters:
- XLEN, 32, data and address width; only 32 is supported.
- RESET_PC_UNUSED, 0, reserved; must stay 0; no function.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  datapath request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  load zero-extends when 1; ignored for stores.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; valid only with resp_valid on a load; 0 otherwise.
- resp_err  out  1  with resp_valid: illegal size, or misaligned access when trap is enabled.
- mem_addr  out  32  word address; bits [1:0] always 00.
- mem_re  out  1  RAM read enable.
- mem_we  out  4  RAM byte write mask; bit i writes lane i, bits [8i+7:8i].
- mem_wdata  out  32  lane-shifted store data.
- mem_rdata  in  32  RAM read data, valid the cycle after mem_re.

Behaviour:
- All outputs are registered or decoded from state.
- Reset values: req_ready=1 and every other output 0.
- States: IDLE, ACC0, ACC1, RESP.
- Accept: at cycle N, when IDLE and req_valid, the unit latches the request and moves to ACC0 (or RESP for an error case).
- Split condition: half with addr[1:0]=11, or word with addr[1:0]≠00. Bytes never split.
- ACC0 (N+1): mem_addr = {addr[31:2],00}.
  - Store: mem_we = size mask shifted left by addr[1:0], truncated to 4 bits; mem_wdata = wdata shifted left by 8·addr[1:0].
  - Load: mem_re = 1.
  - Next state is ACC1 if split, else RESP.
- ACC1 (N+2): mem_addr = word0 + 4, wrapping from 0xFFFFFFFC to 0x00000000.
  - Store: mem_we carries the spilled lanes; mem_wdata carries the spilled bytes in the low lanes.
  - Load: captures the word0 mem_rdata and asserts mem_re.
- RESP: resp_valid = 1 for exactly one cycle, then IDLE.
  - Load data is assembled from the captured word0 and the live mem_rdata, shifted right by 8·addr[1:0], then extended from bit 7 or bit 15 unless req_unsigned.
- Latency from accept:
  - Aligned load and aligned store: resp_valid at N+2.
  - Split load and split store: resp_valid at N+3.
- Illegal size 11: no RAM enables, resp_err=1, resp_valid at N+1.
- mem_re and mem_we are never both nonzero in the same cycle. Both are 0 in IDLE and RESP.
- req_valid outside IDLE is ignored; the datapath must hold the request until req_ready.
- Reset mid-operation returns the unit to IDLE next edge with all outputs at their reset values. A write already issued is not undone. No resp_valid is produced for the aborted request.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: a split-condition access is not performed. It behaves like illegal size (no RAM enables, resp_err=1, resp_valid at N+1), and ACC1 is unreachable.
- Undefined: split accesses proceed as described, and resp_err is set only for size 11.

Decomposition:
- Package lsu_pkg:
  - size enum {SZ_B, SZ_H, SZ_W, SZ_ILL}.
  - state enum {IDLE, ACC0, ACC1, RESP}.
  - Constants for the size-to-mask table: 0001, 0011, 1111.
- One sub-module, lsu_lane_shift: purely combinational.
  - Store path: produces the 8-byte mask and data window for a given offset and size.
  - Load path: performs extraction and sign/zero extension.
  - The top level owns the FSM, latches and RAM sequencing.

Test Plan:
- Aligned word store at 0x100, data 0xDEADBEEF -> ACC0 drives mem_addr=0x100, mem_we=1111, mem_wdata=0xDEADBEEF; resp_valid at N+2, resp_err=0.
- Byte load at 0x103 with RAM word 0x80xxxxxx: signed -> resp_rdata=0xFFFFFF80; unsigned -> 0x00000080; mem_re only in ACC0.
- Split word load at 0x102, RAM[0x100]=0x4433xxxx, RAM[0x104]=0xxxxx6655 -> two reads at 0x100 then 0x104, resp_rdata=0x66554433 at N+3.
- Split half store at 0x0FF, data 0xBBAA -> cycle N+1: addr 0x0FC, mem_we=1000, lane3=0xAA; cycle N+2: addr 0x100, mem_we=0001, lane0=0xBB.
- req_size=11 at any address -> no mem enables; resp_valid and resp_err=1 at N+1. With LSU_MISALIGN_TRAP_EN, a word at 0x101 gives the same result.
- rst asserted during ACC1 of a split store -> next cycle IDLE, req_ready=1, mem_we=0000, no resp_valid. A following aligned load completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: size/state encodings and the size-to-byte-mask table shared by the load/store unit
package lsu_pkg;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_ILL} size_t;
    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;
    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;
    function automatic logic [3:0] size_mask(size_t s);
        return s == SZ_B ? MASK_B : s == SZ_H ? MASK_H : s == SZ_W ? MASK_W : 4'b0000;
    endfunction
endpackage

// File: rtl/lsu_lane_shift.sv
// lsu_lane_shift: byte-lane alignment of store data/mask over a two-word window, and load extraction with extension
module lsu_lane_shift
    import lsu_pkg::*;
(
    input  logic [1:0]  off,
    input  size_t       size,
    input  logic        uns,
    input  logic [31:0] wdata,
    input  logic [31:0] lo,
    input  logic [31:0] hi,
    output logic [7:0]  mask,
    output logic [63:0] wwin,
    output logic [31:0] rdata
);
    logic [31:0] win;
    always_comb begin
        mask = {4'b0000, size_mask(size)} << off;
        wwin = {32'b0, wdata} << {off, 3'b000};
        win = 32'({hi, lo} >> {off, 3'b000});
        rdata = size == SZ_B ? {{24{~uns & win[7]}}, win[7:0]} :
                size == SZ_H ? {{16{~uns & win[15]}}, win[15:0]} : win;
    end
endmodule

// File: rtl/lsu_align_unit.sv
// lsu_align_unit: aligns byte/half/word requests onto a word RAM, splitting word-crossing accesses in two cycles.
// Define LSU_MISALIGN_TRAP_EN to fault split-condition accesses instead of performing them.
module lsu_align_unit
    import lsu_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter int RESET_PC_UNUSED = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_re,
    output logic [3:0]      mem_we,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);
    if (XLEN != 32 || RESET_PC_UNUSED != 0) begin : g_bad_cfg
        $error("lsu_align_unit: only XLEN=32 with RESET_PC_UNUSED=0 is supported");
    end
    state_t state;
    size_t size_in, size_q;
    logic we_q, uns_q, err_q, split_q, split, err, acc0, acc1;
    logic [XLEN-1:0] addr_q, wdata_q, w0_q, ldata;
    logic [7:0] mask8;
    logic [63:0] wwin;
    assign size_in = size_t'(req_size);
    assign split = (size_in == SZ_H && req_addr[1:0] == 2'b11) || (size_in == SZ_W && req_addr[1:0] != 2'b00);
`ifdef LSU_MISALIGN_TRAP_EN
    assign err = size_in == SZ_ILL || split;
`else
    assign err = size_in == SZ_ILL;
`endif
    lsu_lane_shift u_shift (
        .off  (addr_q[1:0]),
        .size (size_q),
        .uns  (uns_q),
        .wdata(wdata_q),
        .lo   (split_q ? w0_q : mem_rdata),
        .hi   (mem_rdata),
        .mask (mask8),
        .wwin (wwin),
        .rdata(ldata)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            split_q <= 1'b0;
            size_q  <= SZ_B;
            addr_q  <= '0;
            wdata_q <= '0;
            w0_q    <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    we_q    <= req_we;
                    uns_q   <= req_unsigned;
                    err_q   <= err;
                    split_q <= split;
                    size_q  <= size_in;
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                    state   <= err ? RESP : ACC0;
                end
                ACC0: state <= split_q ? ACC1 : RESP;
                ACC1: begin
                    w0_q  <= mem_rdata;
                    state <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // Everything below decodes from state, so reset and IDLE/RESP leave the RAM side quiet
    always_comb begin
        acc0       = state == ACC0;
        acc1       = state == ACC1;
        req_ready  = state == IDLE;
        resp_valid = state == RESP;
        resp_err   = resp_valid & err_q;
        resp_rdata = (resp_valid & ~we_q & ~err_q) ? ldata : '0;
        mem_addr   = acc0 ? {addr_q[XLEN-1:2], 2'b00} :
                     acc1 ? {addr_q[XLEN-1:2] + (XLEN-2)'(1), 2'b00} : '0;
        mem_re     = ~we_q & (acc0 | acc1);
        mem_we     = ~we_q ? 4'b0000 : acc0 ? mask8[3:0] : acc1 ? mask8[7:4] : 4'b0000;
        mem_wdata  = ~we_q ? '0 : acc0 ? wwin[31:0] : acc1 ? wwin[63:32] : '0;
    end
endmodule

// File: tb/tb_lsu_align_unit.sv
// tb_lsu_align_unit: scoreboard bench with a byte-level RAM model behind the unit
module tb_lsu_align_unit;
    logic clk = 0, rst = 1;
    logic req_valid = 0, req_we = 0, req_unsigned = 0;
    logic [1:0] req_size = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic req_ready, resp_valid, resp_err, mem_re;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata, rd_q;
    logic [3:0] mem_we;
    logic [7:0] bmem [0:4095];
    typedef struct {logic [31:0] rdata; logic err; int cyc;} exp_t;
    exp_t sbq[$];
    int checks = 0, failures = 0, cyc = 0;

    always #5 clk = ~clk;

    lsu_align_unit dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr),
        .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    assign mem_rdata = rd_q;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_re)
            rd_q <= {bmem[mem_addr[11:0] + 12'd3], bmem[mem_addr[11:0] + 12'd2],
                     bmem[mem_addr[11:0] + 12'd1], bmem[mem_addr[11:0]]};
        for (int i = 0; i < 4; i++)
            if (mem_we[i]) bmem[mem_addr[11:0] + 12'(i)] <= mem_wdata[8*i +: 8];
    end

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
        logic [31:0] v;
        int n;
        v = 0;
        n = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
        for (int i = 0; i < n; i++) v[8*i +: 8] = bmem[12'(a + 32'(i))];
        if (!uns && sz == 2'd0) v = {{24{v[7]}}, v[7:0]};
        if (!uns && sz == 2'd1) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    always @(negedge clk) begin
        exp_t x;
        if (!rst) begin
            checks++;
            if ((mem_re && mem_we != 4'b0) || mem_addr[1:0] != 2'b00) begin
                failures++;
                $display("FAIL mem_side re=%b we=%b addr=%h", mem_re, mem_we, mem_addr);
            end
            if (resp_valid) begin
                checks++;
                if (sbq.size() == 0) begin
                    failures++;
                    $display("FAIL spurious_resp got resp_valid=1 want no response (cyc %0d)", cyc);
                end else begin
                    x = sbq.pop_front();
                    if (resp_rdata !== x.rdata || resp_err !== x.err || cyc != x.cyc) begin
                        failures++;
                        $display("FAIL resp got rdata=%h err=%b cyc=%0d want rdata=%h err=%b cyc=%0d",
                                 resp_rdata, resp_err, cyc, x.rdata, x.err, x.cyc);
                    end
                end
            end
        end
    end

    task automatic issue(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                         input logic [31:0] wd, input bit push, output int e);
        exp_t x;
        bit spl, er;
        int k;
        k = 0;
        @(negedge clk);
        while (!req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (!req_ready) begin
            failures++;
            $display("FAIL ready_timeout got req_ready=0 want 1");
        end
        req_valid = 1; req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1;
        e = cyc;
        req_valid = 0;
        spl = (sz == 2'd1 && a[1:0] == 2'd3) || (sz == 2'd2 && a[1:0] != 2'd0);
        er = sz == 2'd3;
`ifdef LSU_MISALIGN_TRAP_EN
        er = er || spl;
`endif
        x.err = er;
        x.rdata = (we || er) ? 32'h0 : model_load(a, sz, uns);
        x.cyc = e + (er ? 0 : spl ? 2 : 1);
        if (push) sbq.push_back(x);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (sbq.size() != 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL resp_timeout got %0d pending want 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || {resp_valid, resp_err, mem_re, mem_we} !== 7'b0 ||
            resp_rdata !== 0 || mem_addr !== 0 || mem_wdata !== 0) begin
            failures++;
            $display("FAIL reset_state got ready=%b rv=%b re=%b we=%b want ready=1 rest 0",
                     req_ready, resp_valid, mem_re, mem_we);
        end
        rst = 0;
    endtask

    task automatic test_aligned_store();
        int e;
        issue(1, 2'd2, 0, 32'h100, 32'hDEADBEEF, 1, e);
        @(negedge clk);
        checks++;
        if (mem_addr !== 32'h100 || mem_we !== 4'b1111 || mem_wdata !== 32'hDEADBEEF || mem_re !== 0) begin
            failures++;
            $display("FAIL st_word_acc0 got addr=%h we=%b wd=%h want 100 1111 deadbeef", mem_addr, mem_we, mem_wdata);
        end
        wait_idle();
    endtask

    task automatic test_byte_load();
        int e;
        issue(1, 2'd2, 0, 32'h100, 32'h80112233, 1, e);
        for (int u = 0; u < 2; u++) begin
            issue(0, 2'd0, 1'(u), 32'h103, 0, 1, e);
            @(negedge clk);
            checks++;
            if (mem_re !== 1 || mem_addr !== 32'h100) begin
                failures++;
                $display("FAIL ld_byte_acc0 got re=%b addr=%h want 1 100", mem_re, mem_addr);
            end
            @(negedge clk);
            checks++;
            if (mem_re !== 0 || resp_rdata !== (u == 0 ? 32'hFFFFFF80 : 32'h00000080)) begin
                failures++;
                $display("FAIL ld_byte_resp got re=%b rdata=%h want re=0 rdata=%h", mem_re, resp_rdata,
                         u == 0 ? 32'hFFFFFF80 : 32'h00000080);
            end
        end
        wait_idle();
    endtask

    task automatic test_split_load();
        int e;
        issue(1, 2'd2, 0, 32'h100, 32'h44331111, 1, e);
        issue(1, 2'd2, 0, 32'h104, 32'h22226655, 1, e);
        issue(0, 2'd2, 0, 32'h102, 0, 1, e);
        @(negedge clk);
        checks++;
        if (mem_re !== 1 || mem_addr !== 32'h100) begin
            failures++;
            $display("FAIL split_ld_acc0 got re=%b addr=%h want 1 100", mem_re, mem_addr);
        end
        @(negedge clk);
        checks++;
        if (mem_re !== 1 || mem_addr !== 32'h104) begin
            failures++;
            $display("FAIL split_ld_acc1 got re=%b addr=%h want 1 104", mem_re, mem_addr);
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 1 || resp_rdata !== 32'h66554433) begin
            failures++;
            $display("FAIL split_ld_resp got rv=%b rdata=%h want 1 66554433", resp_valid, resp_rdata);
        end
        wait_idle();
    endtask

    task automatic test_split_store();
        int e;
        issue(1, 2'd1, 0, 32'h0FF, 32'h0000BBAA, 1, e);
        @(negedge clk);
        checks++;
        if (mem_addr !== 32'h0FC || mem_we !== 4'b1000 || mem_wdata[31:24] !== 8'hAA) begin
            failures++;
            $display("FAIL split_st_acc0 got addr=%h we=%b lane3=%h want 0fc 1000 aa", mem_addr, mem_we, mem_wdata[31:24]);
        end
        @(negedge clk);
        checks++;
        if (mem_addr !== 32'h100 || mem_we !== 4'b0001 || mem_wdata[7:0] !== 8'hBB) begin
            failures++;
            $display("FAIL split_st_acc1 got addr=%h we=%b lane0=%h want 100 0001 bb", mem_addr, mem_we, mem_wdata[7:0]);
        end
        issue(0, 2'd1, 1, 32'h0FF, 0, 1, e);
        issue(1, 2'd2, 0, 32'hFFFFFFFE, 32'hCAFEF00D, 1, e);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (mem_addr !== 32'h0 || mem_we !== 4'b0011) begin
            failures++;
            $display("FAIL wrap_acc1 got addr=%h we=%b want 00000000 0011", mem_addr, mem_we);
        end
        issue(0, 2'd2, 0, 32'hFFFFFFFE, 0, 1, e);
        wait_idle();
    endtask

    task automatic test_illegal();
        int e;
        issue(0, 2'd3, 0, 32'h123, 0, 1, e);
        @(negedge clk);
        checks++;
        if (resp_valid !== 1 || resp_err !== 1 || mem_re !== 0 || mem_we !== 0) begin
            failures++;
            $display("FAIL illegal got rv=%b err=%b re=%b we=%b want 1 1 0 0", resp_valid, resp_err, mem_re, mem_we);
        end
        issue(1, 2'd3, 0, 32'h200, 32'h1, 1, e);
        wait_idle();
    endtask

    task automatic test_reset_abort();
        int e;
        issue(1, 2'd2, 0, 32'h0F2, 32'h11223344, 0, e);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (mem_we !== 4'b0011 || mem_addr !== 32'h0F4) begin
            failures++;
            $display("FAIL abort_acc1 got we=%b addr=%h want 0011 0f4", mem_we, mem_addr);
        end
        rst = 1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1 || mem_we !== 0 || mem_re !== 0 || resp_valid !== 0 || resp_err !== 0) begin
            failures++;
            $display("FAIL abort_reset got ready=%b we=%b re=%b rv=%b want 1 0000 0 0", req_ready, mem_we, mem_re, resp_valid);
        end
        rst = 0;
        issue(0, 2'd2, 0, 32'h0F0, 0, 1, e);
        wait_idle();
    endtask

    task automatic test_back_to_back();
        int e;
        for (int w = 0; w < 68; w++) issue(1, 2'd2, 0, 32'h200 + 32'(4 * w), $urandom, 1, e);
        for (int i = 0; i < 80; i++)
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  32'h200 + 32'($urandom_range(0, 255)), $urandom, 1, e);
        wait_idle();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout got no finish want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_aligned_store();
        test_byte_load();
        test_illegal();
`ifndef LSU_MISALIGN_TRAP_EN
        test_split_load();
        test_split_store();
        test_reset_abort();
`endif
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
